// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
// The output buffer depth is fixed at two entries by the read-issue pacing.
package nv_ram_fifo_pkg;

  localparam int WIDTH_DEF  = 1088;
  localparam int DEPTH_DEF  = 64;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);
  localparam int OBUF_DEPTH = 2;

  // A read may issue only if the buffer can still absorb it when its data lands.
  function automatic logic obuf_has_room(input logic [1:0] cnt,
                                         input logic       inflight,
                                         input logic       rd_acc);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, inflight};
    return occ < (3'(OBUF_DEPTH) + {2'b00, rd_acc});
  endfunction

endpackage

// File: rtl/nv_ram_fifo_obuf.sv
// Two-entry output buffer behind the RAM read port.
// An arriving word is visible on the output in its arrival cycle when the buffer is empty.
module nv_ram_fifo_obuf
  import nv_ram_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [OBUF_DEPTH];
  logic             head_r;
  logic             tail_r;
  logic [1:0]       cnt_r;
  logic             empty_s;
  logic             bypass_s;
  logic             store_s;
  logic             deq_s;
  logic [1:0]       cnt_nxt_s;

  // Output selection and occupancy update.
  always_comb begin
    empty_s   = (cnt_r == 2'd0);
    out_vld   = ~empty_s | in_vld;
    out_pd    = empty_s ? in_pd : mem_r[head_r];
    bypass_s  = empty_s & in_vld & out_rdy;
    store_s   = in_vld & ~bypass_s;
    deq_s     = ~empty_s & out_rdy;
    cnt_nxt_s = cnt_r + {1'b0, store_s} - {1'b0, deq_s};
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= 2'd0;
      head_r <= 1'b0;
      tail_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (store_s) tail_r <= ~tail_r;
      if (deq_s)   head_r <= ~head_r;
    end
  end

  // Payload storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (store_s) mem_r[tail_r] <= in_pd;
  end

  assign count = cnt_r;

endmodule

// File: rtl/nv_ram_fifo_ctrl.sv
// FIFO controller driving an external single-cycle-latency RAM,
// with a two-entry output buffer that hides the RAM read latency.
module nv_ram_fifo_ctrl
  import nv_ram_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW:0]      fifo_count,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   ram_cnt_r;
  logic [AW:0]   ram_cnt_nxt_s;
  logic [AW:0]   fifo_count_r;
  logic [AW:0]   fifo_count_nxt_s;
  logic          inflight_r;
  logic          wr_acc_s;
  logic          rd_acc_s;
  logic          ram_re_s;
  logic          obuf_vld_s;
  logic [1:0]    obuf_cnt_s;

  // Handshakes, read-issue decision and next occupancy.
  always_comb begin
    wr_prdy          = ~reset & (ram_cnt_r != FULL_CNT);
    wr_acc_s         = wr_pvld & wr_prdy;
    rd_pvld          = ~reset & obuf_vld_s;
    rd_acc_s         = rd_pvld & rd_prdy;
    ram_re_s         = ~reset & (ram_cnt_r != ZERO_CNT) &
                       obuf_has_room(obuf_cnt_s, inflight_r, rd_acc_s);
    ram_cnt_nxt_s    = ram_cnt_r + {AW'(0), wr_acc_s} - {AW'(0), ram_re_s};
    fifo_count_nxt_s = ram_cnt_nxt_s + {AW'(0), ram_re_s} +
                       {(AW-1)'(0), obuf_cnt_s} + {AW'(0), inflight_r} -
                       {AW'(0), rd_acc_s};
  end

  // Pointers, RAM occupancy and read pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      ram_cnt_r    <= ZERO_CNT;
      inflight_r   <= 1'b0;
      fifo_count_r <= ZERO_CNT;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (ram_re_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      ram_cnt_r    <= ram_cnt_nxt_s;
      inflight_r   <= ram_re_s;
      fifo_count_r <= fifo_count_nxt_s;
    end
  end

  nv_ram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (inflight_r),
    .in_pd   (ram_dout),
    .out_vld (obuf_vld_s),
    .out_rdy (rd_prdy),
    .out_pd  (rd_pd),
    .count   (obuf_cnt_s)
  );

  assign ram_we            = wr_acc_s;
  assign ram_wa            = wr_ptr_r;
  assign ram_di            = wr_pd;
  assign ram_re            = ram_re_s;
  assign ram_ra            = rd_ptr_r;
  assign fifo_count        = fifo_count_r;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_fifo_ctrl.sv
// Directed self-checking bench for nv_ram_fifo_ctrl with a behavioural RAM model.
module tb_nv_ram_fifo_ctrl;

  localparam int WIDTH = 1088;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk;
  logic             reset;
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_di;
  logic             ram_re;
  logic [AW-1:0]    ram_ra;
  logic [WIDTH-1:0] ram_dout;
  logic [AW:0]      fifo_count;
  logic [31:0]      pwrbus_ram_pd;
  logic [31:0]      ram_pwrbus_ram_pd;

  logic [WIDTH-1:0] ram_mem [DEPTH];

  int n_checks;
  int n_fail;
  int wa_model;
  int ra_model;

  nv_ram_fifo_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_we            (ram_we),
    .ram_wa            (ram_wa),
    .ram_di            (ram_di),
    .ram_re            (ram_re),
    .ram_ra            (ram_ra),
    .ram_dout          (ram_dout),
    .fifo_count        (fifo_count),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  // External RAM: write on we, read data one cycle after re.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= ram_mem[ram_ra];
  end

  function automatic logic [WIDTH-1:0] pl(input int v);
    pl = {34{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_pvld = 1'b1; wr_pd = pl(7); rd_prdy = 1'b1;
    step(); #1;
    n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_prdy: got %b want 0", wr_prdy); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram_re: got %b want 0", ram_re); end
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld: got %b want 0", rd_pvld); end
    n_checks++; if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    step();
    reset = 1'b0; wr_pvld = 1'b0; #1;
    n_checks++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_prdy: got %b want 1", wr_prdy); end
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd_pvld: got %b want 0", rd_pvld); end
    wa_model = 0;
  endtask

  task automatic test_latency();
    step();
    wr_pvld = 1'b1; wr_pd = pl(1); rd_prdy = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL lat_c0_ram_we: got %b want 1", ram_we); end
    n_checks++; if (ram_wa !== 6'd0) begin n_fail++; $display("FAIL lat_c0_ram_wa: got %0d want 0", ram_wa); end
    n_checks++; if (ram_di !== pl(1)) begin n_fail++; $display("FAIL lat_c0_ram_di: got %0h want %0h", ram_di, pl(1)); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL lat_c0_ram_re: got %b want 0", ram_re); end
    wa_model++;
    step();
    wr_pvld = 1'b0; #1;
    n_checks++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL lat_c1_ram_re: got %b want 1", ram_re); end
    n_checks++; if (ram_ra !== 6'd0) begin n_fail++; $display("FAIL lat_c1_ram_ra: got %0d want 0", ram_ra); end
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_c1_rd_pvld: got %b want 0", rd_pvld); end
    n_checks++; if (fifo_count !== 7'd1) begin n_fail++; $display("FAIL lat_c1_fifo_count: got %0d want 1", fifo_count); end
    step(); #1;
    n_checks++; if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL lat_c2_rd_pvld: got %b want 1", rd_pvld); end
    n_checks++; if (rd_pd !== pl(1)) begin n_fail++; $display("FAIL lat_c2_rd_pd: got %0h want %0h", rd_pd, pl(1)); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL lat_c2_ram_re: got %b want 0", ram_re); end
    step(); #1;
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_c3_rd_pvld: got %b want 0", rd_pvld); end
    n_checks++; if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL lat_c3_fifo_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_fill_full_toggle();
    int wi;
    int ri;
    int cyc;
    wi = 0; ri = 0; cyc = 0;
    while (wi < 66 && cyc < 200) begin
      step();
      wr_pvld = 1'b1; wr_pd = pl(100 + wi); rd_prdy = 1'b0; #1;
      if (wr_prdy) begin
        n_checks++; if (ram_wa !== wa_model[AW-1:0]) begin n_fail++; $display("FAIL fill_ram_wa: got %0d want %0d", ram_wa, wa_model[AW-1:0]); end
        wa_model++; wi++;
      end
      cyc++;
    end
    n_checks++; if (cyc !== 66) begin n_fail++; $display("FAIL fill_cycles: got %0d want 66", cyc); end
    step();
    wr_pvld = 1'b1; wr_pd = pl(999); #1;
    n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL full_wr_prdy: got %b want 0", wr_prdy); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL full_ram_we: got %b want 0", ram_we); end
    n_checks++; if (fifo_count !== 7'd66) begin n_fail++; $display("FAIL full_fifo_count: got %0d want 66", fifo_count); end
    for (int k = 0; k < 8; k++) begin
      step();
      rd_prdy = (k % 2 == 0); wr_pvld = 1'b1; wr_pd = pl(100 + wi); #1;
      n_checks++; if (fifo_count < 7'd65 || fifo_count > 7'd66) begin n_fail++; $display("FAIL toggle_fifo_count: got %0d want 65..66", fifo_count); end
      n_checks++; if (wr_prdy !== (k % 2 == 1)) begin n_fail++; $display("FAIL toggle_wr_prdy k=%0d: got %b want %b", k, wr_prdy, (k % 2 == 1)); end
      if (rd_pvld && rd_prdy) begin
        n_checks++; if (rd_pd !== pl(100 + ri)) begin n_fail++; $display("FAIL toggle_rd_pd: got %0h want %0h", rd_pd, pl(100 + ri)); end
        ri++;
      end
      if (wr_prdy) begin wa_model++; wi++; end
    end
    n_checks++; if (ri !== 4 || wi !== 70) begin n_fail++; $display("FAIL toggle_counts: got rd=%0d wr=%0d want rd=4 wr=70", ri, wi); end
    cyc = 0;
    while (ri < wi && cyc < 300) begin
      step();
      wr_pvld = 1'b0; rd_prdy = 1'b1; #1;
      if (rd_pvld) begin
        n_checks++; if (rd_pd !== pl(100 + ri)) begin n_fail++; $display("FAIL drain_rd_pd idx=%0d: got %0h want %0h", ri, rd_pd, pl(100 + ri)); end
        ri++;
      end
      cyc++;
    end
    n_checks++; if (ri !== 70) begin n_fail++; $display("FAIL drain_count: got %0d want 70", ri); end
    step(); #1;
    n_checks++; if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL drain_fifo_count: got %0d want 0", fifo_count); end
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL drain_rd_pvld: got %b want 0", rd_pvld); end
  endtask

  task automatic test_back_to_back();
    int wi;
    int ri;
    int cyc;
    int first_rd;
    int last_rd;
    int gaps;
    wi = 0; ri = 0; cyc = 0; first_rd = -1; last_rd = 0; gaps = 0;
    ra_model = wa_model;
    while (ri < 200 && cyc < 400) begin
      step();
      wr_pvld = (wi < 200); wr_pd = pl(5000 + wi); rd_prdy = 1'b1; #1;
      if (ram_re) begin
        n_checks++; if (ram_ra !== ra_model[AW-1:0]) begin n_fail++; $display("FAIL b2b_ram_ra: got %0d want %0d", ram_ra, ra_model[AW-1:0]); end
        ra_model++;
      end
      if (wr_pvld && wr_prdy) begin
        n_checks++; if (ram_wa !== wa_model[AW-1:0]) begin n_fail++; $display("FAIL b2b_ram_wa: got %0d want %0d", ram_wa, wa_model[AW-1:0]); end
        wa_model++; wi++;
      end
      if (rd_pvld) begin
        n_checks++; if (rd_pd !== pl(5000 + ri)) begin n_fail++; $display("FAIL b2b_rd_pd idx=%0d: got %0h want %0h", ri, rd_pd, pl(5000 + ri)); end
        if (first_rd < 0) first_rd = cyc;
        else if (cyc != last_rd + 1) gaps++;
        last_rd = cyc; ri++;
      end
      cyc++;
    end
    n_checks++; if (first_rd !== 2) begin n_fail++; $display("FAIL b2b_first_read_cycle: got %0d want 2", first_rd); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    n_checks++; if (ri !== 200 || wi !== 200) begin n_fail++; $display("FAIL b2b_counts: got rd=%0d wr=%0d want 200/200", ri, wi); end
    n_checks++; if (cyc !== 202) begin n_fail++; $display("FAIL b2b_total_cycles: got %0d want 202", cyc); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 11; k++) begin
      step();
      wr_pvld = 1'b1; wr_pd = pl(700 + k); rd_prdy = 1'b0; #1;
    end
    step();
    wr_pvld = 1'b0; rd_prdy = 1'b1; #1;
    n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== pl(700)) begin n_fail++; $display("FAIL mid_first_out: got vld=%b pd=%0h want vld=1 pd=%0h", rd_pvld, rd_pd, pl(700)); end
    n_checks++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL mid_ram_re: got %b want 1", ram_re); end
    step();
    rd_prdy = 1'b0; reset = 1'b1; #1;
    n_checks++; if (fifo_count !== 7'd10) begin n_fail++; $display("FAIL mid_held_count: got %0d want 10", fifo_count); end
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rd_pvld: got %b want 0", rd_pvld); end
    step();
    reset = 1'b0; #1;
    n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL after_reset_rd_pvld: got %b want 0", rd_pvld); end
    n_checks++; if (fifo_count !== 7'd0) begin n_fail++; $display("FAIL after_reset_fifo_count: got %0d want 0", fifo_count); end
    wr_pvld = 1'b1; wr_pd = pl(32'hBEEF); rd_prdy = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b1 || ram_wa !== 6'd0) begin n_fail++; $display("FAIL after_reset_write: got we=%b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    step();
    wr_pvld = 1'b0; #1;
    n_checks++; if (ram_re !== 1'b1 || ram_ra !== 6'd0) begin n_fail++; $display("FAIL after_reset_read_issue: got re=%b ra=%0d want re=1 ra=0", ram_re, ram_ra); end
    step(); #1;
    n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== pl(32'hBEEF)) begin n_fail++; $display("FAIL after_reset_first_out: got vld=%b pd=%0h want vld=1 pd=%0h", rd_pvld, rd_pd, pl(32'hBEEF)); end
    step(); #1;
    n_checks++; if (fifo_count !== 7'd0 || rd_pvld !== 1'b0) begin n_fail++; $display("FAIL after_reset_empty: got cnt=%0d vld=%b want 0/0", fifo_count, rd_pvld); end
  endtask

  task automatic test_pwrbus();
    pwrbus_ram_pd = 32'hA5A5_0001; #1;
    n_checks++; if (ram_pwrbus_ram_pd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL pwrbus_a: got %0h want a5a50001", ram_pwrbus_ram_pd); end
    pwrbus_ram_pd = 32'h5A5A_FFFE; #1;
    n_checks++; if (ram_pwrbus_ram_pd !== 32'h5A5A_FFFE) begin n_fail++; $display("FAIL pwrbus_b: got %0h want 5a5afffe", ram_pwrbus_ram_pd); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; reset = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    pwrbus_ram_pd = 32'h0; n_checks = 0; n_fail = 0; wa_model = 0; ra_model = 0;
    test_reset();
    test_latency();
    test_fill_full_toggle();
    test_back_to_back();
    test_reset_mid();
    test_pwrbus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
